// File: rtl/display_controller.sv
// VGA-style raster timing generator: pixel-rate divider, h/v scan counters,
// active-low syncs, visible-window flag and a completed-frame time base.
module display_controller #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_START = 144,
    parameter int H_END   = 783,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_START = 35,
    parameter int V_END   = 514,
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pixel_tick,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    // A divide-by-one build still needs a one-bit divider register.
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]      H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0]      V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0]      H_FIRST  = 10'(H_START);
    localparam logic [9:0]      H_FINAL  = 10'(H_END);
    localparam logic [9:0]      V_FIRST  = 10'(V_START);
    localparam logic [9:0]      V_FINAL  = 10'(V_END);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic             r_frame_tick;
    logic [7:0]       r_frame_cnt;

    logic w_pixel_tick;
    logic w_h_wrap;
    logic w_frame_wrap;

    assign w_pixel_tick = (r_div_cnt == DIV_LAST);
    assign w_h_wrap     = w_pixel_tick && (r_h_cnt == H_LAST);
    assign w_frame_wrap = w_h_wrap && (r_v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            if (w_pixel_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if (w_h_wrap) begin
                r_h_cnt <= '0;
            end else if (w_pixel_tick) begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end

            if (w_frame_wrap) begin
                r_v_cnt <= '0;
            end else if (w_h_wrap) begin
                r_v_cnt <= r_v_cnt + 10'd1;
            end

            // Pulse lands in the first cycle of the new frame, alongside (0,0).
            r_frame_tick <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign hCount     = r_h_cnt;
    assign vCount     = r_v_cnt;
    assign hSync      = (r_h_cnt >= H_SYNC_W);
    assign vSync      = (r_v_cnt >= V_SYNC_W);
    assign bright     = (r_h_cnt >= H_FIRST) && (r_h_cnt <= H_FINAL) &&
                        (r_v_cnt >= V_FIRST) && (r_v_cnt <= V_FINAL);
    assign pixel_tick = w_pixel_tick;
    assign frame_tick = r_frame_tick;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_display_controller.sv
// Randomised-reset bench for display_controller: a default-timing instance for
// line-level behaviour and a shrunken-timing instance for frame and wrap behaviour.
module tb_display_controller;

    // Shrunken raster so hundreds of frames fit in a short run.
    localparam int S_CD = 2, S_HT = 12, S_HS = 2, S_HST = 3, S_HEN = 9;
    localparam int S_VT = 8, S_VS = 1, S_VST = 2, S_VEN = 5;
    localparam int S_FRAME = S_CD * S_HT * S_VT;

    logic clk;
    logic rst_n;

    logic [9:0] d_hCount, d_vCount, s_hCount, s_vCount;
    logic       d_hSync, d_vSync, d_bright, d_pixel_tick, d_frame_tick;
    logic       s_hSync, s_vSync, s_bright, s_pixel_tick, s_frame_tick;
    logic [7:0] d_frame_cnt, s_frame_cnt;

    int n;
    int tests;
    int fails;

    display_controller dut_d (
        .clk        (clk),
        .rst_n      (rst_n),
        .hCount     (d_hCount),
        .vCount     (d_vCount),
        .hSync      (d_hSync),
        .vSync      (d_vSync),
        .bright     (d_bright),
        .pixel_tick (d_pixel_tick),
        .frame_tick (d_frame_tick),
        .frame_cnt  (d_frame_cnt)
    );

    display_controller #(
        .H_TOTAL (S_HT), .H_SYNC (S_HS), .H_START (S_HST), .H_END (S_HEN),
        .V_TOTAL (S_VT), .V_SYNC (S_VS), .V_START (S_VST), .V_END (S_VEN),
        .CLK_DIV (S_CD)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .hCount     (s_hCount),
        .vCount     (s_vCount),
        .hSync      (s_hSync),
        .vSync      (s_vSync),
        .bright     (s_bright),
        .pixel_tick (s_pixel_tick),
        .frame_tick (s_frame_tick),
        .frame_cnt  (s_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference time base: clk edges elapsed since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t n=%0d actual=%0d expected=%0d", name, $time, n, act, exp);
        end
    endtask

    // Expected raster state from the edge count alone: pixel index, then
    // column/line/frame by division.
    task automatic check_vga(input string tag, input int cnt,
                             input int cd, input int ht, input int hs, input int hst, input int hen,
                             input int vt, input int vs, input int vst, input int ven,
                             input logic [9:0] h, input logic [9:0] v,
                             input logic hsy, input logic vsy, input logic br,
                             input logic pt, input logic ft, input logic [7:0] fc);
        int p, eh, ev, fl;
        p  = cnt / cd;
        eh = p % ht;
        ev = (p / ht) % vt;
        fl = cd * ht * vt;
        chk({tag, ".hCount"},     int'(h),   eh);
        chk({tag, ".vCount"},     int'(v),   ev);
        chk({tag, ".hSync"},      int'(hsy), (eh < hs) ? 0 : 1);
        chk({tag, ".vSync"},      int'(vsy), (ev < vs) ? 0 : 1);
        chk({tag, ".bright"},     int'(br),
            (eh >= hst && eh <= hen && ev >= vst && ev <= ven) ? 1 : 0);
        chk({tag, ".pixel_tick"}, int'(pt),  (cnt % cd == cd - 1) ? 1 : 0);
        chk({tag, ".frame_tick"}, int'(ft),  (cnt > 0 && cnt % fl == 0) ? 1 : 0);
        chk({tag, ".frame_cnt"},  int'(fc),  (cnt / fl) % 256);
    endtask

    always @(negedge clk) begin
        check_vga("dflt", n, 4, 800, 96, 144, 783, 525, 2, 35, 514,
                  d_hCount, d_vCount, d_hSync, d_vSync, d_bright,
                  d_pixel_tick, d_frame_tick, d_frame_cnt);
        check_vga("small", n, S_CD, S_HT, S_HS, S_HST, S_HEN, S_VT, S_VS, S_VST, S_VEN,
                  s_hCount, s_vCount, s_hSync, s_vSync, s_bright,
                  s_pixel_tick, s_frame_tick, s_frame_cnt);
        if (rst_n) begin
            case (n)
                3:     begin chk("lit.d_tick_edge3", int'(d_pixel_tick), 1);
                             chk("lit.d_h_edge3", int'(d_hCount), 0); end
                4:     chk("lit.d_h_edge4", int'(d_hCount), 1);
                380:   chk("lit.d_hsync_h95", int'(d_hSync), 0);
                384:   chk("lit.d_hsync_h96", int'(d_hSync), 1);
                3199:  begin chk("lit.d_h799", int'(d_hCount), 799);
                             chk("lit.d_v0", int'(d_vCount), 0); end
                3200:  begin chk("lit.d_hwrap", int'(d_hCount), 0);
                             chk("lit.d_v1", int'(d_vCount), 1); end
                34:    chk("lit.s_bright_v1", int'(s_bright), 0);
                52:    chk("lit.s_bright_h2", int'(s_bright), 0);
                54:    chk("lit.s_bright_first", int'(s_bright), 1);
                138:   chk("lit.s_bright_last", int'(s_bright), 1);
                140:   chk("lit.s_bright_h10", int'(s_bright), 0);
                150:   chk("lit.s_bright_v6", int'(s_bright), 0);
                191:   begin chk("lit.s_fc_before", int'(s_frame_cnt), 0);
                             chk("lit.s_ft_before", int'(s_frame_tick), 0); end
                192:   begin chk("lit.s_ft_wrap", int'(s_frame_tick), 1);
                             chk("lit.s_fc_wrap", int'(s_frame_cnt), 1);
                             chk("lit.s_h_wrap", int'(s_hCount), 0);
                             chk("lit.s_v_wrap", int'(s_vCount), 0); end
                193:   chk("lit.s_ft_after", int'(s_frame_tick), 0);
                49151: chk("lit.s_fc_255", int'(s_frame_cnt), 255);
                49152: begin chk("lit.s_fc_roll", int'(s_frame_cnt), 0);
                             chk("lit.s_ft_roll", int'(s_frame_tick), 1); end
                default: ;
            endcase
        end
    end

    // Reset is asserted 2 time units after an edge; check 1 unit later,
    // well before the next edge, that everything has already cleared.
    task automatic assert_reset_and_check();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async.d_hCount", int'(d_hCount), 0);
        chk("async.d_vCount", int'(d_vCount), 0);
        chk("async.d_pixel_tick", int'(d_pixel_tick), 0);
        chk("async.d_hSync", int'(d_hSync), 0);
        chk("async.d_vSync", int'(d_vSync), 0);
        chk("async.d_bright", int'(d_bright), 0);
        chk("async.d_frame_cnt", int'(d_frame_cnt), 0);
        chk("async.s_hCount", int'(s_hCount), 0);
        chk("async.s_vCount", int'(s_vCount), 0);
        chk("async.s_pixel_tick", int'(s_pixel_tick), 0);
        chk("async.s_frame_tick", int'(s_frame_tick), 0);
        chk("async.s_frame_cnt", int'(s_frame_cnt), 0);
    endtask

    task automatic release_reset(input int hold);
        repeat (hold) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        release_reset(3);

        // Long enough to cover a full default line wrap.
        repeat (6600) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            assert_reset_and_check();
            release_reset($urandom_range(5, 1));
            repeat ($urandom_range(3000, 50)) @(posedge clk);
        end

        // Uninterrupted run through the frame counter rollover.
        assert_reset_and_check();
        release_reset($urandom_range(4, 1));
        repeat (256 * S_FRAME + 400) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
